// File: rtl/alu_exec_stage.sv
// ---------------------------------------------------------------------------
// alu_exec_stage
//
// Execute stage that sits after the ALU control decoder. It accepts one
// operation per valid/ready handshake, computes a registered result, a zero
// flag and an illegal-code flag, and presents them under a second valid/ready
// handshake downstream.
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid && ready are both high. A producer holds its payload stable while
// valid is high and ready is low. This stage never drops out_valid before
// the downstream handshake completes.
//
// Add, subtract, logic and I-type operations finish in one cycle. Shifts run
// on a bit-serial shifter, one bit per cycle. Upstream is held off while a
// shift is in progress.
//
// Ports:
//   clk          sole clock; all state updates on the rising edge
//   reset        synchronous, active-high reset
//   in_valid     upstream presents a valid operation
//   in_ready     stage can accept an operation this cycle (combinational)
//   alu_control  3-bit operation code
//   op_a         first operand (rs)
//   op_b         second operand (rt or sign-extended immediate)
//   shamt        shift amount
//   out_valid    result / zero / illegal are valid
//   out_ready    downstream accepts the result
//   result       registered result
//   zero         registered, 1 when result == 0
//   illegal      registered, 1 when the accepted code was 3'b110
//   state_dbg    current FSM state (0 IDLE, 1 SHIFT, 2 DONE), for observation
// ---------------------------------------------------------------------------
module alu_exec_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [4:0]       shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic [1:0]       state_dbg
);

    // Operation codes from the ALU control decoder.
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_ILL = 3'b110;
    localparam logic [2:0] OP_ITY = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] work;        // bit-serial shifter working register
    logic [4:0]       cnt;         // remaining shift steps
    logic             shift_right; // latched direction: 1 = SRL, 0 = SLL

    logic             accept;
    logic             is_shift;
    logic             go_shift;
    logic [WIDTH-1:0] fast_result;
    logic [WIDTH-1:0] shift_next;

    // ------------------------------------------------------------------
    // Upstream ready. A DONE stage can take a new op only on the same edge
    // its own result leaves, so the single output register never overflows.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        if (!reset) begin
            in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
        end
    end

    assign accept    = in_valid && in_ready;
    assign state_dbg = state;

    // ------------------------------------------------------------------
    // Single-cycle datapath. A shift with shamt == 0 is also single-cycle
    // and simply passes op_b through.
    // ------------------------------------------------------------------
    always_comb begin
        fast_result = '0;
        case (alu_control)
            OP_ADD:  fast_result = op_a + op_b;
            OP_SUB:  fast_result = op_a - op_b;
            OP_AND:  fast_result = op_a & op_b;
            OP_OR:   fast_result = op_a | op_b;
            OP_SLL:  fast_result = op_b;
            OP_SRL:  fast_result = op_b;
            OP_ITY:  fast_result = op_a + op_b;
            OP_ILL:  fast_result = '0;
            default: fast_result = '0;
        endcase
    end

    assign is_shift = (alu_control == OP_SLL) || (alu_control == OP_SRL);
    assign go_shift = is_shift && (shamt != 5'd0);

    // One-bit step of the serial shifter. Shifting WIDTH or more times
    // naturally drains the register to zero, so oversize amounts need no
    // special case.
    assign shift_next = shift_right ? (work >> 1) : (work << 1);

    // ------------------------------------------------------------------
    // Control FSM and output registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            out_valid   <= 1'b0;
            result      <= '0;
            zero        <= 1'b0;
            illegal     <= 1'b0;
            work        <= '0;
            cnt         <= 5'd0;
            shift_right <= 1'b0;
        end else begin
            case (state)
                ST_SHIFT: begin
                    work <= shift_next;
                    cnt  <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        // Last step: publish the shifted value directly.
                        result    <= shift_next;
                        zero      <= (shift_next == '0);
                        illegal   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end

                ST_IDLE, ST_DONE: begin
                    // IDLE and DONE share the acceptance path, so a DONE
                    // stage with out_ready high behaves exactly like IDLE.
                    if (accept) begin
                        if (go_shift) begin
                            work        <= op_b;
                            cnt         <= shamt;
                            shift_right <= (alu_control == OP_SRL);
                            out_valid   <= 1'b0;
                            state       <= ST_SHIFT;
                        end else begin
                            result    <= fast_result;
                            zero      <= (fast_result == '0);
                            illegal   <= (alu_control == OP_ILL);
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end else if ((state == ST_DONE) && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_stage
//
// Directed table-driven bench for alu_exec_stage: a vector table of
// single operations with hand-computed results and latencies, followed by
// hand-written sequences for back-to-back throughput, downstream stall and
// reset in the middle of a shift.
// ---------------------------------------------------------------------------
module tb_alu_exec_stage;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   alu_control;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [4:0]   shamt;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         illegal;
    logic [1:0]   state_dbg;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];

    alu_exec_stage #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .op_a        (op_a),
        .op_b        (op_b),
        .shamt       (shamt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .illegal     (illegal),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0]   ctrl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [4:0]   sh;
        logic [W-1:0] res;
        logic         z;
        logic         ill;
        int           lat;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one operation and wait for its result, checking latency and
    // that in_ready stays low while a shift runs.
    task automatic run_vec(input int i);
        int     lat;
        logic [W-1:0] exp_res;
        @(negedge clk);
        alu_control = vecs[i].ctrl;
        op_a        = vecs[i].a;
        op_b        = vecs[i].b;
        shamt       = vecs[i].sh;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        exp_q.push_back(vecs[i].res);
        #1;
        check($sformatf("v%0d in_ready_at_issue", i), W'(in_ready), W'(1));
        @(negedge clk);
        // Scramble inputs after acceptance; the op in flight must ignore them.
        in_valid    = 1'b0;
        alu_control = 3'($urandom_range(0, 7));
        op_a        = $urandom;
        op_b        = $urandom;
        shamt       = 5'($urandom_range(0, 31));
        lat = 1;
        while (!out_valid && lat < 60) begin
            check($sformatf("v%0d in_ready_busy", i), W'(in_ready), W'(0));
            @(negedge clk);
            lat++;
        end
        check($sformatf("v%0d out_valid", i), W'(out_valid), W'(1));
        check($sformatf("v%0d latency", i), W'(lat), W'(vecs[i].lat));
        exp_res = exp_q.pop_front();
        check($sformatf("v%0d result", i), result, exp_res);
        check($sformatf("v%0d zero", i), W'(zero), W'(vecs[i].z));
        check($sformatf("v%0d illegal", i), W'(illegal), W'(vecs[i].ill));
    endtask

    task automatic issue(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] s);
        alu_control = c;
        op_a        = a;
        op_b        = b;
        shamt       = s;
        in_valid    = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        vecs[0]  = '{3'b000, 32'd5,        32'd7,        5'd0,  32'd12,       1'b0, 1'b0, 1};
        vecs[1]  = '{3'b001, 32'd9,        32'd9,        5'd0,  32'd0,        1'b1, 1'b0, 1};
        vecs[2]  = '{3'b000, 32'hFFFFFFFF, 32'd1,        5'd0,  32'd0,        1'b1, 1'b0, 1};
        vecs[3]  = '{3'b001, 32'd0,        32'd1,        5'd0,  32'hFFFFFFFF, 1'b0, 1'b0, 1};
        vecs[4]  = '{3'b111, 32'h100,      32'hFFFFFFFC, 5'd0,  32'hFC,       1'b0, 1'b0, 1};
        vecs[5]  = '{3'b100, 32'd0,        32'd1,        5'd4,  32'h10,       1'b0, 1'b0, 5};
        vecs[6]  = '{3'b101, 32'd0,        32'h80000000, 5'd31, 32'd1,        1'b0, 1'b0, 32};
        vecs[7]  = '{3'b100, 32'd0,        32'hABCD,     5'd0,  32'hABCD,     1'b0, 1'b0, 1};
        vecs[8]  = '{3'b110, 32'd5,        32'd3,        5'd0,  32'd0,        1'b1, 1'b1, 1};
        vecs[9]  = '{3'b010, 32'hF0,       32'h3C,       5'd0,  32'h30,       1'b0, 1'b0, 1};
        vecs[10] = '{3'b011, 32'hF0,       32'h0F,       5'd0,  32'hFF,       1'b0, 1'b0, 1};
        vecs[11] = '{3'b101, 32'd0,        32'hF0,       5'd4,  32'h0F,       1'b0, 1'b0, 5};
        vecs[12] = '{3'b100, 32'd0,        32'h80000001, 5'd1,  32'd2,        1'b0, 1'b0, 2};
        vecs[13] = '{3'b101, 32'd0,        32'd1,        5'd1,  32'd0,        1'b1, 1'b0, 2};
        vecs[14] = '{3'b110, 32'hFFFF,     32'h1234,     5'd7,  32'd0,        1'b1, 1'b1, 1};

        reset       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        alu_control = 3'b000;
        op_a        = '0;
        op_b        = '0;
        shamt       = 5'd0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst in_ready", W'(in_ready), W'(0));
        check("rst out_valid", W'(out_valid), W'(0));
        check("rst result", result, W'(0));
        check("rst zero", W'(zero), W'(0));
        check("rst illegal", W'(illegal), W'(0));
        check("rst state", W'(state_dbg), W'(0));
        reset = 1'b0;
        #1;
        check("post_rst in_ready", W'(in_ready), W'(1));

        // ---- table ----
        for (int i = 0; i < NV; i++) run_vec(i);

        // Let the last result drain.
        @(negedge clk);
        check("drain out_valid", W'(out_valid), W'(0));

        // ---- back-to-back single-cycle ops, one result per cycle ----
        out_ready = 1'b1;
        issue(3'b000, 32'd1, 32'd2, 5'd0);
        @(negedge clk);
        check("b2b r0", result, W'(3));
        check("b2b v0", W'(out_valid), W'(1));
        check("b2b rdy0", W'(in_ready), W'(1));
        issue(3'b001, 32'd10, 32'd4, 5'd0);
        @(negedge clk);
        check("b2b r1", result, W'(6));
        check("b2b v1", W'(out_valid), W'(1));
        issue(3'b011, 32'h100, 32'h001, 5'd0);
        @(negedge clk);
        check("b2b r2", result, W'(32'h101));
        check("b2b v2", W'(out_valid), W'(1));
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b end", W'(out_valid), W'(0));

        // ---- downstream stall, then release with a pending op ----
        issue(3'b000, 32'd3, 32'd4, 5'd0);
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            issue(3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)));
            #1;
            check($sformatf("stall in_ready c%0d", c), W'(in_ready), W'(0));
            check($sformatf("stall out_valid c%0d", c), W'(out_valid), W'(1));
            check($sformatf("stall result c%0d", c), result, W'(7));
            @(negedge clk);
        end
        issue(3'b011, 32'hF0, 32'h0F, 5'd0);
        out_ready = 1'b1;
        #1;
        check("release in_ready", W'(in_ready), W'(1));
        check("release old result", result, W'(7));
        @(negedge clk);
        in_valid = 1'b0;
        check("release new valid", W'(out_valid), W'(1));
        check("release new result", result, W'(32'hFF));
        @(negedge clk);
        check("release drain", W'(out_valid), W'(0));

        // ---- reset in the middle of a shift ----
        issue(3'b100, 32'd0, 32'd1, 5'd20);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_shift state", W'(state_dbg), W'(1));
        reset = 1'b1;
        @(negedge clk);
        check("mrst out_valid", W'(out_valid), W'(0));
        check("mrst result", result, W'(0));
        check("mrst in_ready", W'(in_ready), W'(0));
        reset = 1'b0;
        #1;
        check("mrst in_ready after", W'(in_ready), W'(1));
        lat = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (out_valid) lat++;
        end
        check("mrst no stale result", W'(lat), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Execute stage that sits directly downstream of the ALU control decoder. It consumes the 3-bit `alu_control` code together with two operands and a shift amount, then produces a registered result and a zero flag under a valid/ready handshake. Add, subtract, logic and I-type operations complete in one cycle. Shifts use an iterative one-bit-per-cycle shifter, so the stage holds off upstream while a shift is in progress.

## Interface

Parameters:
- `WIDTH`, 32, datapath width in bits.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream presents a valid operation.
- `in_ready`  out  1  stage can accept an operation this cycle.
- `alu_control`  in  3  operation code from the ALU control decoder.
- `op_a`  in  WIDTH  first operand (rs).
- `op_b`  in  WIDTH  second operand (rt, or sign-extended immediate for I-type).
- `shamt`  in  5  shift amount.
- `out_valid`  out  1  `result`, `zero` and `illegal` are valid.
- `out_ready`  in  1  downstream accepts the result.
- `result`  out  WIDTH  registered result.
- `zero`  out  1  registered; 1 when `result == 0`.
- `illegal`  out  1  registered; 1 when the accepted code was `3'b110`.

## Operation

- Codes:
  - `000` ADD: a+b.
  - `001` SUB: a−b.
  - `010` AND.
  - `011` OR.
  - `100` SLL: `op_b << shamt`.
  - `101` SRL: `op_b >> shamt`, logical.
  - `111` I-type: a+b.
  - `110` illegal: `result = 0`, `illegal = 1`.
- Arithmetic wraps modulo 2^WIDTH. There is no overflow or carry output.
- If `shamt >= WIDTH`, the shift result is 0. This falls out of the bit-serial shifter.
- Inputs are sampled only at acceptance (`in_valid && in_ready` at a rising edge). Later changes to inputs do not affect an operation in flight.
- FSM states are IDLE, SHIFT and DONE.
  - IDLE, on acceptance:
    - Non-shift op, or shift with `shamt == 0`: go to DONE with `result` loaded.
    - Shift with `shamt = n > 0`: load the working register with `op_b` and the counter with n, then go to SHIFT.
  - SHIFT: each edge shifts the working register by one bit in the latched direction and decrements the counter. On the edge where the counter goes 1→0, the final value is written to `result` and the state goes to DONE.
  - DONE: `out_valid = 1`.
    - On `out_valid && out_ready` with no new acceptance, go to IDLE.
    - If a new operation is accepted in the same cycle, process it exactly as from IDLE.
- `in_ready` is combinational: `(state == IDLE) || (state == DONE && out_ready)`. It is 0 while `reset` is high.
- `result`, `zero` and `illegal` are stable from the cycle `out_valid` rises until the handshake completes.
- Reset values: state IDLE, `out_valid` 0, `result` 0, `zero` 0, `illegal` 0, counter 0.
- Reset during SHIFT or DONE discards the operation. No result is emitted.

## Timing

- Acceptance at edge k:
  - Non-shift op, or `shamt == 0`: `out_valid` is high from cycle k+1 (latency 1).
  - Shift with `shamt = n > 0`: `out_valid` is high from cycle k+n+1 (latency n+1). `in_ready` is 0 throughout SHIFT.
- Back-to-back single-cycle ops with `out_ready` held at 1 sustain one result per cycle.
- With `out_ready = 0` in DONE, `in_ready = 0`. Outputs hold indefinitely and no input is consumed.
- `zero` and `illegal` update on the same edge as `result`.

## Test plan

- Reset, then ADD `op_a=5`, `op_b=7` with `out_ready=1` → one cycle later `out_valid=1`, `result=12`, `zero=0`. In a second test, SUB `9−9` → `result=0`, `zero=1`.
- ADD `0xFFFFFFFF + 1` → `result=0`, `zero=1`. SUB `0 − 1` → `result=0xFFFFFFFF`. I-type `0x100 + 0xFFFFFFFC` → `result=0xFC`.
- SLL `op_b=1`, `shamt=4` → `in_ready` low for 4 cycles, `out_valid` at k+5, `result=0x10`. SRL `op_b=0x80000000`, `shamt=31` → `result=1` at k+32. SLL with `shamt=0` → latency 1, `result=op_b`.
- Code `110` → `result=0`, `illegal=1`, `zero=1` at latency 1. A following AND `0xF0 & 0x3C` → `result=0x30`, `illegal=0`.
- Hold `out_ready=0` for 5 cycles in DONE while toggling inputs → `result` stable and `in_ready=0`. Release it with a valid OR pending → handshake and acceptance occur on the same edge, and the next result appears the following cycle.
- Assert `reset` mid-SHIFT (`shamt=20`, cycle 5) → next cycle `out_valid=0`, `result=0`, `in_ready=1` after reset deasserts, and no stale result is ever emitted.
